// File: rtl/cic_comp_fir_if.sv
// Sample stream between the CIC decimator, the droop-compensation FIR and the
// next baseband stage. The source drives master and the filter takes slave.
interface cic_comp_fir_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16
);
  logic signed [DATA_W-1:0] din;
  logic                     din_val;
  logic signed [OUT_W-1:0]  dout;
  logic                     dout_val;
  logic                     busy;
  logic                     sat;
  logic                     ovf;

  modport master (
    output din, din_val,
    input  dout, dout_val, busy, sat, ovf
  );

  modport slave (
    input  din, din_val,
    output dout, dout_val, busy, sat, ovf
  );
endinterface

// File: rtl/cic_comp_fir.sv
// 7-tap symmetric CIC droop-compensation FIR at the decimated rate, sharing one
// multiplier over four cycles per sample, with round-half-up and saturation to OUT_W.
module cic_comp_fir #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 22,
  parameter int C0     = -128,
  parameter int C1     = 512,
  parameter int C2     = -2048,
  parameter int C3     = 19712
) (
  input  logic           clk50,
  input  logic           rst,
  cic_comp_fir_if.slave  bus
);

  localparam int ACC_W = DATA_W + COEF_W + 3;
  localparam int PRE_W = DATA_W + 1;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] YMAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] YMIN = -(ACC_W'(1) <<< (OUT_W - 1));

  typedef enum logic {IDLE, MAC} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               k;
  logic signed [DATA_W-1:0] x [7];
  logic signed [ACC_W-1:0]  acc;
  logic signed [PRE_W-1:0]  pre;
  logic signed [COEF_W-1:0] coef;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [OUT_W:0]           conv;

  logic signed [OUT_W-1:0]  dout_r;
  logic                     dout_val_r;
  logic                     sat_r;
  logic                     ovf_r;

  function automatic logic signed [PRE_W-1:0] sx(input logic signed [DATA_W-1:0] v);
    return PRE_W'(v);
  endfunction

  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v);
    return (v + HALF) >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > YMAX) return {1'b1, YMAX[OUT_W-1:0]};
    if (v < YMIN) return {1'b1, YMIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  // Tap pair selection: symmetric taps are pre-added so one multiply covers two taps.
  always_comb begin
    pre  = sx(x[3]);
    coef = COEF_W'(C3);
    case (k)
      2'd0: begin pre = sx(x[0]) + sx(x[6]); coef = COEF_W'(C0); end
      2'd1: begin pre = sx(x[1]) + sx(x[5]); coef = COEF_W'(C1); end
      2'd2: begin pre = sx(x[2]) + sx(x[4]); coef = COEF_W'(C2); end
      default: ;
    endcase
    prod    = ACC_W'(pre) * ACC_W'(coef);
    acc_sum = acc + prod;
    conv    = saturate(round_shift(acc_sum));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.din_val) state_nxt = MAC;
      MAC:     if (k == 2'd3)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Delay line, accumulator and output registers
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) x[i] <= '0;
      k          <= 2'd0;
      acc        <= '0;
      dout_r     <= '0;
      dout_val_r <= 1'b0;
      sat_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      dout_val_r <= 1'b0;
      sat_r      <= 1'b0;
      if (state == IDLE) begin
        if (bus.din_val) begin
          x[0] <= bus.din;
          for (int i = 1; i < 7; i++) x[i] <= x[i-1];
          acc <= '0;
          k   <= 2'd0;
        end
      end else begin
        if (bus.din_val) ovf_r <= 1'b1;
        k <= k + 2'd1;
        if (k == 2'd3) begin
          dout_r     <= conv[OUT_W-1:0];
          sat_r      <= conv[OUT_W];
          dout_val_r <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign bus.dout     = dout_r;
  assign bus.dout_val = dout_val_r;
  assign bus.sat      = sat_r;
  assign bus.ovf      = ovf_r;
  assign bus.busy     = (state == MAC);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: fixed vector table, overflow and reset-abort sequences,
// then random traffic against a convolution-level reference model.
module tb_cic_comp_fir;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #10 clk50 = ~clk50;

  cic_comp_fir_if bus ();

  cic_comp_fir dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic signed [31:0] din;
    int                 dout;
    bit                 sat;
    bit                 chk;
  } vec_t;

  typedef struct {
    int due;
    int y;
    bit s;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   h[7]   = '{-128, 512, -2048, 19712, -2048, 512, -128};

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: full 7-tap convolution, round half up, clip to 16 bits.
  function automatic void ref_out(input longint hist[7], output int y, output bit s);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < 7; i++) acc += longint'(h[i]) * hist[i];
    r = (acc + (64'sd1 <<< 21)) >>> 22;
    s = 1'b0;
    if (r > 32767)       begin y = 32767;  s = 1'b1; end
    else if (r < -32768) begin y = -32768; s = 1'b1; end
    else                 y = int'(r);
  endfunction

  task automatic do_reset();
    bus.din_val = 1'b0;
    rst = 1'b1;
    @(negedge clk50);
    @(negedge clk50);
    rst = 1'b0;
    @(negedge clk50);
  endtask

  // Starts at a negedge, returns at the negedge after the output edge (T+4).
  task automatic send(input logic signed [31:0] d, output logic signed [15:0] y,
                      output logic s, output logic [4:0] vpat, output logic [4:0] bpat);
    y = 'x;
    s = 'x;
    bus.din     = d;
    bus.din_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk50);
      bus.din_val = 1'b0;
      vpat[i] = bus.dout_val;
      bpat[i] = bus.busy;
      if (bus.dout_val) begin
        y = bus.dout;
        s = bus.sat;
      end
    end
  endtask

  task automatic run_vec(input int lo, input int hi);
    logic signed [15:0] y;
    logic               s;
    logic [4:0]         vp, bp;
    for (int i = lo; i <= hi; i++) begin
      send(vecs[i].din, y, s, vp, bp);
      check($sformatf("vld_timing[%0d]", i), vp, 5'b10000);
      check($sformatf("busy_timing[%0d]", i), bp, 5'b01111);
      if (vecs[i].chk) begin
        check($sformatf("dout[%0d]", i), y, vecs[i].dout);
        check($sformatf("sat[%0d]", i), s, vecs[i].sat);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] y;
    logic               s;
    logic [4:0]         vp, bp;
    logic signed [31:0] d;
    longint             hist[7];
    int                 last_acc;
    bit                 m_ovf;
    int                 cnt;
    int                 ry;
    bit                 rs;
    bit                 v;

    // impulse 2^22
    vecs.push_back('{32'sd4194304, -128, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 512, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, -2048, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 19712, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, -2048, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 512, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, -128, 1'b0, 1'b1});
    // rounding impulse 2^13
    vecs.push_back('{32'sd8192, 0, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 1, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, -4, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 39, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, -4, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 1, 1'b0, 1'b1});
    vecs.push_back('{32'sd0, 0, 1'b0, 1'b1});
    // DC 100000: partial tap sums, then unity gain
    vecs.push_back('{32'sd100000, -3, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, 9, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, -40, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, 430, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, 381, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, 394, 1'b0, 1'b1});
    vecs.push_back('{32'sd100000, 391, 1'b0, 1'b1});
    // DC +2^26: transition from DC history unchecked, then clipped high
    for (int i = 0; i < 3; i++) vecs.push_back('{32'sd67108864, 0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back('{32'sd67108864, 32767, 1'b1, 1'b1});
    // DC -2^26 after +2^26 history
    for (int i = 0; i < 3; i++) vecs.push_back('{-32'sd67108864, 32767, 1'b1, 1'b1});
    for (int i = 0; i < 4; i++) vecs.push_back('{-32'sd67108864, -32768, 1'b1, 1'b1});

    bus.din     = '0;
    bus.din_val = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk50);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_val", bus.dout_val, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(negedge clk50);

    run_vec(0, vecs.size() - 1);
    check("ovf_clear_after_table", bus.ovf, 0);

    // Second sample at T+3 is dropped, the first still completes at T+4.
    do_reset();
    cnt = 0;
    bus.din     = 32'sd4194304;
    bus.din_val = 1'b1;
    @(negedge clk50);
    bus.din_val = 1'b0;
    cnt += int'(bus.dout_val);
    check("ovf_before_drop", bus.ovf, 0);
    @(negedge clk50);
    cnt += int'(bus.dout_val);
    @(negedge clk50);
    cnt += int'(bus.dout_val);
    bus.din     = 32'sd12345;
    bus.din_val = 1'b1;
    @(negedge clk50);
    bus.din_val = 1'b0;
    cnt += int'(bus.dout_val);
    check("ovf_set_at_drop", bus.ovf, 1);
    @(negedge clk50);
    cnt += int'(bus.dout_val);
    check("ovf_first_out", bus.dout, -128);
    check("ovf_one_strobe", cnt, 1);
    run_vec(1, 6);
    check("ovf_sticky", bus.ovf, 1);

    // Asynchronous reset in the middle of a computation.
    bus.din     = 32'sd4194304;
    bus.din_val = 1'b1;
    @(negedge clk50);
    bus.din_val = 1'b0;
    @(negedge clk50);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_ovf", bus.ovf, 0);
    check("abort_dout", bus.dout, 0);
    check("abort_sat", bus.sat, 0);
    check("abort_dout_val", bus.dout_val, 0);
    @(negedge clk50);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk50);
      cnt += int'(bus.dout_val);
    end
    check("abort_no_strobe", cnt, 0);
    run_vec(0, 6);

    // Random traffic, including inputs that arrive too early.
    do_reset();
    for (int i = 0; i < 7; i++) hist[i] = 0;
    last_acc = -100;
    m_ovf    = 1'b0;
    for (int e = 0; e < 3000; e++) begin
      v = (e < 2990) && ($urandom_range(0, 99) < 30);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = $signed($urandom_range(0, 2097152)) - 32'sd1048576;
        2:       d = $signed($urandom_range(0, 268435456)) - 32'sd134217728;
        default: d = ($urandom_range(0, 1) != 0) ? 32'sh7fffffff : 32'sh80000000;
      endcase
      bus.din     = d;
      bus.din_val = v;
      if (v) begin
        if (e - last_acc >= 5) begin
          for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = longint'(d);
          ref_out(hist, ry, rs);
          expq.push_back('{e + 4, ry, rs});
          last_acc = e;
        end else begin
          m_ovf = 1'b1;
        end
      end
      @(negedge clk50);
      if (expq.size() > 0 && expq[0].due == e) begin
        check($sformatf("rnd_vld@%0d", e), bus.dout_val, 1);
        check($sformatf("rnd_dout@%0d", e), bus.dout, expq[0].y);
        check($sformatf("rnd_sat@%0d", e), bus.sat, expq[0].s);
        void'(expq.pop_front());
      end else begin
        check($sformatf("rnd_idle_vld@%0d", e), bus.dout_val, 0);
      end
    end
    bus.din_val = 1'b0;
    check("rnd_pending", expq.size(), 0);
    check("rnd_ovf", bus.ovf, m_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Droop-compensation decimated-rate FIR that sits directly downstream of the CIC decimator. It consumes the CIC's 32-bit signed output and its one-cycle valid strobe, and applies a 7-tap symmetric FIR with one time-multiplexed multiplier. The result is rounded and saturated to 16 bits for the next baseband stage. The block also flags samples that arrive too close together to be processed.

## Interface
- InWidth, 32, input sample width (signed); matches CIC OutDataWidth
- OutWidth, 16, output sample width (signed)
- CoefWidth, 16, coefficient width (signed, Q1.14)
- Shift, 22, arithmetic right shift applied to the accumulator before output
- C0, -128, outer taps h0/h6
- C1, 512, taps h1/h5
- C2, -2048, taps h2/h4
- C3, 19712, centre tap h3; tap sum = 16384, giving unity DC gain

Ports:
- clk50  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- din  in  InWidth  CIC output sample, signed
- din_val  in  1  single-cycle strobe qualifying din
- dout  out  OutWidth  filtered sample, signed
- dout_val  out  1  single-cycle strobe qualifying dout
- busy  out  1  high while a sample is being processed
- sat  out  1  high together with dout_val when that output was clipped
- ovf  out  1  sticky flag: an input sample was dropped; cleared only by rst

## Operation
- Delay line x0..x6 (InWidth each) holds the newest sample at x0.
- States:
  - IDLE: on din_val, shift din into x0, clear the accumulator, set k=0, go to MAC.
  - MAC: 2-bit counter k counts 0..3. Each cycle performs acc += pre(k) * Ck.
    - pre(k) = x[k] + x[6-k] for k=0..2 (InWidth+1 bits, sign-extended).
    - pre(3) = x3, with no doubling.
  - At k=3 the block does not write acc. It registers the output from acc + pre(3)*C3, pulses dout_val, and returns to IDLE.
- Accumulator width: InWidth+CoefWidth+3 = 51 bits, full precision, no internal overflow.
- Output conversion:
  - y = (acc_final + 2^(Shift-1)) >>> Shift, i.e. round half up (toward +inf).
  - Saturate y to [-2^(OutWidth-1), 2^(OutWidth-1)-1].
  - sat = 1 if clipping occurred.
- din_val while in MAC: the sample is dropped, the delay line is unchanged, ovf is set to 1, and the current computation completes normally.
- busy = 1 in MAC, 0 in IDLE.
- dout holds its last value between strobes.

## Timing
- Reset values: dout=0, dout_val=0, sat=0, busy=0, ovf=0, state=IDLE, x0..x6=0, acc=0.
- The reset is asynchronous. Asserting rst mid-computation aborts the computation with no dout_val, and all state returns to reset values.
- Let din_val be sampled at edge T (state IDLE). Then:
  - MAC runs at edges T+1..T+4.
  - dout, dout_val and sat are registered at edge T+4 and are high for exactly one cycle.
  - Latency is 4 clocks.
- Minimum input spacing is 5 clocks. At edge T+4 the state returns to IDLE, so din_val at T+5 is accepted; din_val at T+1..T+4 is dropped.
- With the CIC decimation factor ≥ 5, no drops occur.
- Sustained throughput is one output per accepted input.

## Test plan
- Impulse: din=2^22 once, followed by 6 zero samples, all spaced 5 clocks → dout sequence -128, 512, -2048, 19712, -2048, 512, -128, each 4 clocks after its din_val, with sat=0.
- DC: din=100000 held for ≥7 strobes → dout from the 7th output onward = 391 (100000·16384/2^22 = 390.625, rounded up). The first six outputs follow the partial tap sums.
- Rounding: impulse din=2^13 → centre output 39 (38.5 rounds up); outer outputs 0 (-0.25 rounds to 0); h2 output -4 (exact).
- Saturation: DC din=2^26 → steady dout=32767 with sat=1. DC din=-2^26 → steady dout=-32768 with sat=1.
- Overflow: din_val at T and at T+3 → exactly one dout_val at T+4. ovf=1 from T+3 and stays set; the delay line holds only the first sample, and a following valid impulse spaced 5 clocks filters correctly.
- Reset mid-op: din_val at T, rst pulsed at T+2 → no dout_val; all outputs and ovf are 0; the next impulse after reset reproduces the impulse-test sequence.
